// File: rtl/mat_cache_pkg.sv
// mat_cache_pkg: shared command/state encodings and element type for the matrix cache.
package mat_cache_pkg;
    typedef enum logic [3:0] {
        OP_NOP, OP_WRITE_ROW, OP_WRITE_COL, OP_WRITE_DIAG,
        OP_READ_ROW, OP_READ_COL, OP_READ_DIAG, OP_TRANSPOSE, OP_CLEAR
    } MatCacheOp_t;
    typedef enum logic [1:0] {IDLE, XPOSE, CLEAR} MatCacheState_t;
    // Elements are carried as IEEE-754 single-precision bit patterns; the cache never does arithmetic on them.
    typedef logic [31:0] elem_t;
    localparam elem_t ZERO = 32'h0000_0000;
endpackage

// File: rtl/mat_cache_seq_ctrl.sv
// mat_cache_seq_ctrl: command acceptance, TRANSPOSE/CLEAR sequencer and datapath enables.
module mat_cache_seq_ctrl
    import mat_cache_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int WIDTH_ADDR_SIZE = 1 + $clog2(WIDTH),
    parameter int CACHE_ADDR_SIZE = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cmd_valid,
    input  MatCacheOp_t                cmd_op,
    input  logic [CACHE_ADDR_SIZE-1:0] cmd_addr1,
    output logic                       cmd_ready,
    output logic                       busy,
    output logic                       wr_row,
    output logic                       wr_col,
    output logic                       wr_diag,
    output logic                       rd,
    output logic                       xpose,
    output logic                       clr,
    output logic [WIDTH_ADDR_SIZE-1:0] k,
    output logic [CACHE_ADDR_SIZE-1:0] addr
);
    MatCacheState_t state;
    logic acc;
    logic [WIDTH_ADDR_SIZE-1:0] last;
    assign acc = cmd_valid && cmd_ready && !reset;
    assign wr_row = acc && cmd_op == OP_WRITE_ROW;
    assign wr_col = acc && cmd_op == OP_WRITE_COL;
    assign wr_diag = acc && cmd_op == OP_WRITE_DIAG;
    assign rd = acc && (cmd_op == OP_READ_ROW || cmd_op == OP_READ_COL || cmd_op == OP_READ_DIAG);
    // Sequencer steps are suppressed in the reset cycle so an abort leaves no further edits behind.
    assign xpose = state == XPOSE && !reset;
    assign clr = state == CLEAR && !reset;
    assign last = state == XPOSE ? WIDTH_ADDR_SIZE'(WIDTH - 2) : WIDTH_ADDR_SIZE'(WIDTH - 1);
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            k <= '0;
            busy <= 1'b0;
            cmd_ready <= 1'b1;
        end else if (state == IDLE) begin
            if (acc && (cmd_op == OP_TRANSPOSE || cmd_op == OP_CLEAR)) begin
                state <= cmd_op == OP_TRANSPOSE ? XPOSE : CLEAR;
                k <= '0;
                addr <= cmd_addr1;
                busy <= 1'b1;
                cmd_ready <= 1'b0;
            end
        end else if (k == last) begin
            state <= IDLE;
            busy <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            k <= k + 1'b1;
        end
    end
endmodule

// File: rtl/mat_cache_seq.sv
// mat_cache_seq: tile storage with row/column/split-diagonal access and sequenced transpose/clear.
module mat_cache_seq
    import mat_cache_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CACHE_SIZE = 4,
    parameter int WIDTH_ADDR_SIZE = 1 + $clog2(WIDTH),
    parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  MatCacheOp_t                cmd_op,
    input  logic [CACHE_ADDR_SIZE-1:0] cmd_addr1,
    input  logic [CACHE_ADDR_SIZE-1:0] cmd_addr2,
    input  logic [WIDTH_ADDR_SIZE-1:0] cmd_param,
    input  elem_t                      data_in [WIDTH],
    output logic                       rd_valid,
    output elem_t                      data_out [WIDTH],
    output logic                       busy
);
    localparam int IW = $clog2(WIDTH);
    elem_t mem [CACHE_SIZE][WIDTH][WIDTH];
    elem_t rv [WIDTH];
    logic [CACHE_ADDR_SIZE-1:0] dt [WIDTH];
    logic [IW-1:0] dc [WIDTH];
    logic wr_row, wr_col, wr_diag, rd, xpose, clr;
    logic [WIDTH_ADDR_SIZE-1:0] k;
    logic [CACHE_ADDR_SIZE-1:0] addr;
    logic [IW-1:0] pi, ki;
    logic is_diag, ok, xa_ok;

    mat_cache_seq_ctrl #(
        .WIDTH(WIDTH), .WIDTH_ADDR_SIZE(WIDTH_ADDR_SIZE), .CACHE_ADDR_SIZE(CACHE_ADDR_SIZE)
    ) u_ctrl (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_addr1(cmd_addr1), .cmd_ready(cmd_ready), .busy(busy),
        .wr_row(wr_row), .wr_col(wr_col), .wr_diag(wr_diag), .rd(rd),
        .xpose(xpose), .clr(clr), .k(k), .addr(addr)
    );

    assign pi = cmd_param[IW-1:0];
    assign ki = k[IW-1:0];
    assign is_diag = cmd_op == OP_WRITE_DIAG || cmd_op == OP_READ_DIAG;
    // The secondary tile only matters when some element falls below the split, i.e. p < WIDTH-1.
    assign ok = int'(cmd_param) < WIDTH && int'(cmd_addr1) < CACHE_SIZE &&
                (!is_diag || int'(cmd_addr2) < CACHE_SIZE || int'(cmd_param) == WIDTH - 1);
    assign xa_ok = int'(addr) < CACHE_SIZE;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            dt[i] = i <= int'(cmd_param) ? cmd_addr1 : cmd_addr2;
            dc[i] = IW'(i <= int'(cmd_param) ? int'(cmd_param) - i : WIDTH + int'(cmd_param) - i);
            rv[i] = !ok ? ZERO :
                    cmd_op == OP_READ_ROW ? mem[cmd_addr1][pi][IW'(i)] :
                    cmd_op == OP_READ_COL ? mem[cmd_addr1][IW'(i)][pi] :
                    mem[dt[i]][IW'(i)][dc[i]];
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (ok && wr_row) mem[cmd_addr1][pi][IW'(i)] <= data_in[i];
            if (ok && wr_col) mem[cmd_addr1][IW'(i)][pi] <= data_in[i];
            if (ok && wr_diag) mem[dt[i]][IW'(i)][dc[i]] <= data_in[i];
            if (xpose && xa_ok && i > int'(k)) begin
                mem[addr][ki][IW'(i)] <= mem[addr][IW'(i)][ki];
                mem[addr][IW'(i)][ki] <= mem[addr][ki][IW'(i)];
            end
            if (clr && xa_ok) mem[addr][ki][IW'(i)] <= ZERO;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid <= 1'b0;
            for (int i = 0; i < WIDTH; i++) data_out[i] <= ZERO;
        end else begin
            rd_valid <= rd;
            if (rd) data_out <= rv;
        end
    end
endmodule

// File: tb/tb_mat_cache_seq.sv
// tb_mat_cache_seq: scoreboard bench with a whole-tile reference model of the cache.
module tb_mat_cache_seq;
    import mat_cache_pkg::*;
    localparam int W = 4;
    localparam int CS = 4;
    typedef logic [W*32-1:0] pvec_t;

    logic clock = 0, reset = 1, cmd_valid = 0;
    logic cmd_ready, rd_valid, busy;
    MatCacheOp_t cmd_op = OP_NOP;
    logic [1:0] cmd_addr1 = 0, cmd_addr2 = 0;
    logic [2:0] cmd_param = 0;
    logic [31:0] data_in [W];
    logic [31:0] data_out [W];

    logic [31:0] m [CS][W][W];
    pvec_t q [$];
    int total = 0, passed = 0;

    always #5 clock = ~clock;

    mat_cache_seq #(.WIDTH(W), .CACHE_SIZE(CS)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr1(cmd_addr1), .cmd_addr2(cmd_addr2), .cmd_param(cmd_param),
        .data_in(data_in), .rd_valid(rd_valid), .data_out(data_out), .busy(busy)
    );

    function automatic logic [31:0] fb(int v);
        int e = 0;
        if (v == 0) return 32'h0;
        for (int b = 0; b < 24; b++) if (((v >> b) & 1) != 0) e = b;
        return {1'b0, 8'(127 + e), 23'((v << (23 - e)) & 32'h7fffff)};
    endfunction

    function automatic pvec_t pk_out();
        pvec_t r;
        for (int i = 0; i < W; i++) r[i*32 +: 32] = data_out[i];
        return r;
    endfunction

    function automatic pvec_t exp_read(MatCacheOp_t op, int a1, int a2, int p);
        pvec_t r = '0;
        if (p >= W || a1 >= CS || (op == OP_READ_DIAG && p < W - 1 && a2 >= CS)) return r;
        for (int i = 0; i < W; i++)
            r[i*32 +: 32] = op == OP_READ_ROW ? m[a1][p][i] :
                            op == OP_READ_COL ? m[a1][i][p] :
                            i <= p ? m[a1][i][p-i] : m[a2][i][W+p-i];
        return r;
    endfunction

    task automatic chk(string name, logic [W*32-1:0] got, logic [W*32-1:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic apply(MatCacheOp_t op, int a1, int a2, int p, pvec_t d);
        logic [31:0] t [W][W];
        case (op)
            OP_WRITE_ROW:  if (p < W) for (int i = 0; i < W; i++) m[a1][p][i] = d[i*32 +: 32];
            OP_WRITE_COL:  if (p < W) for (int i = 0; i < W; i++) m[a1][i][p] = d[i*32 +: 32];
            OP_WRITE_DIAG: if (p < W)
                for (int i = 0; i < W; i++)
                    if (i <= p) m[a1][i][p-i] = d[i*32 +: 32];
                    else m[a2][i][W+p-i] = d[i*32 +: 32];
            OP_READ_ROW, OP_READ_COL, OP_READ_DIAG: q.push_back(exp_read(op, a1, a2, p));
            OP_TRANSPOSE: begin
                t = m[a1];
                for (int r = 0; r < W; r++) for (int c = 0; c < W; c++) m[a1][r][c] = t[c][r];
            end
            OP_CLEAR: for (int r = 0; r < W; r++) for (int c = 0; c < W; c++) m[a1][r][c] = 0;
            default: ;
        endcase
    endtask

    task automatic issue(MatCacheOp_t op, int a1, int a2, int p, pvec_t d, output int stall);
        cmd_op = op;
        cmd_addr1 = a1[1:0];
        cmd_addr2 = a2[1:0];
        cmd_param = p[2:0];
        for (int i = 0; i < W; i++) data_in[i] = d[i*32 +: 32];
        cmd_valid = 1;
        stall = 0;
        while (1) begin
            @(negedge clock);
            if (cmd_ready) break;
            chk("busy_while_stalled", W*32'(busy), W*32'(1));
            stall++;
            if (stall > 50) begin
                $display("FAIL cmd_accept_timeout: got ready=0 expected ready=1");
                $fatal(1, "command never accepted");
            end
        end
        @(posedge clock);
        apply(op, a1, a2, p, d);
        #1 cmd_valid = 0;
    endtask

    task automatic go(MatCacheOp_t op, int a1, int a2, int p, pvec_t d);
        int s;
        issue(op, a1, a2, p, d, s);
    endtask

    function automatic pvec_t rnd_vec();
        pvec_t r;
        for (int i = 0; i < W; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    always @(negedge clock) begin
        if (!reset && rd_valid) begin
            if (q.size() == 0) chk("unexpected_rd_valid", W*32'(1), W*32'(0));
            else chk("read_data", pk_out(), q.pop_front());
        end
    end

    initial begin
        pvec_t v;
        int s, b;
        for (int i = 0; i < W; i++) data_in[i] = 0;
        repeat (3) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        chk("reset_busy", W*32'(busy), W*32'(0));
        chk("reset_ready", W*32'(cmd_ready), W*32'(1));
        chk("reset_rd_valid", W*32'(rd_valid), W*32'(0));
        chk("reset_data_out", pk_out(), '0);
        for (int a = 0; a < CS; a++) for (int r = 0; r < W; r++) go(OP_WRITE_ROW, a, 0, r, rnd_vec());

        for (int i = 0; i < W; i++) v[i*32 +: 32] = fb(i + 1);
        go(OP_WRITE_ROW, 1, 0, 2, v);
        go(OP_READ_ROW, 1, 0, 2, '0);
        @(negedge clock);
        chk("rd_valid_pulse", W*32'(rd_valid), W*32'(1));
        @(negedge clock);
        chk("rd_valid_drop", W*32'(rd_valid), W*32'(0));

        for (int r = 0; r < W; r++) begin
            for (int c = 0; c < W; c++) v[c*32 +: 32] = fb(4 * r + c);
            go(OP_WRITE_ROW, 0, 0, r, v);
        end
        go(OP_TRANSPOSE, 0, 0, 0, '0);
        b = 0;
        while (1) begin
            @(negedge clock);
            if (cmd_ready || b > 50) break;
            chk("xpose_busy", W*32'(busy), W*32'(1));
            b++;
        end
        chk("xpose_busy_cycles", W*32'(b), W*32'(W - 1));
        chk("xpose_busy_done", W*32'(busy), W*32'(0));
        @(posedge clock);
        #1;
        go(OP_READ_ROW, 0, 0, 1, '0);
        go(OP_READ_COL, 0, 0, 1, '0);

        for (int i = 0; i < W; i++) v[i*32 +: 32] = fb(10 + i);
        go(OP_WRITE_DIAG, 0, 3, 1, v);
        go(OP_READ_DIAG, 0, 3, 1, '0);
        go(OP_READ_ROW, 3, 0, 2, '0);
        go(OP_READ_ROW, 0, 0, 1, '0);

        go(OP_CLEAR, 2, 0, 0, '0);
        issue(OP_READ_ROW, 2, 0, 0, '0, s);
        chk("clear_stall_cycles", W*32'(s), W*32'(W));
        for (int r = 1; r < W; r++) go(OP_READ_ROW, 2, 0, r, '0);

        go(OP_READ_ROW, 3, 0, 0, '0);
        go(OP_TRANSPOSE, 1, 0, 0, '0);
        @(posedge clock);
        #1 reset = 1;
        @(posedge clock);
        #1 reset = 0;
        chk("abort_busy", W*32'(busy), W*32'(0));
        chk("abort_ready", W*32'(cmd_ready), W*32'(1));
        chk("abort_rd_valid", W*32'(rd_valid), W*32'(0));
        chk("abort_data_out", pk_out(), '0);
        go(OP_WRITE_ROW, 3, 0, 0, rnd_vec());
        go(OP_READ_ROW, 3, 0, 0, '0);
        go(OP_CLEAR, 1, 0, 0, '0);

        go(OP_READ_COL, 0, 0, 5, '0);
        go(OP_WRITE_ROW, 0, 0, 4, rnd_vec());
        for (int r = 0; r < W; r++) go(OP_READ_ROW, 0, 0, r, '0);

        for (int n = 0; n < 120; n++) begin
            int sel = $urandom_range(0, 19);
            MatCacheOp_t op = sel < 2 ? OP_WRITE_ROW : sel < 4 ? OP_WRITE_COL : sel < 6 ? OP_WRITE_DIAG :
                              sel < 9 ? OP_READ_ROW : sel < 12 ? OP_READ_COL : sel < 16 ? OP_READ_DIAG :
                              sel == 16 ? OP_TRANSPOSE : sel == 17 ? OP_CLEAR : OP_NOP;
            go(op, $urandom_range(0, CS - 1), $urandom_range(0, CS - 1), $urandom_range(0, 7), rnd_vec());
        end
        for (int a = 0; a < CS; a++) for (int r = 0; r < W; r++) go(OP_READ_ROW, a, 0, r, '0);

        b = 0;
        while (q.size() != 0 && b < 20) begin
            @(negedge clock);
            b++;
        end
        if (q.size() != 0) chk("reads_outstanding", W*32'(q.size()), '0);
        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
